// File: rtl/unidade_hilo.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Define UNIDADE_HILO_SIGNED_EN to honour op[1] (signed MULT/DIV); otherwise all operations are unsigned.
module unidade_hilo #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               wr_hi,
  input  logic               wr_lo,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] out_64,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] dividend_raw;
  logic             is_div;
  logic             neg_res;
  logic             neg_rem;
  logic             div_zero;

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    cond_neg = en ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic en);
    cond_neg_wide = en ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

`ifdef UNIDADE_HILO_SIGNED_EN
  assign signed_op = op[1];
`else
  logic unused_sign_sel;
  assign signed_op       = 1'b0;
  assign unused_sign_sel = op[1];
`endif

  // Operand conditioning: the core always works on unsigned magnitudes
  assign a_neg = signed_op & in1[WIDTH-1];
  assign b_neg = signed_op & in2[WIDTH-1];
  assign mag_a = cond_neg(in1, a_neg);
  assign mag_b = cond_neg(in2, b_neg);

  // One shift-add step: low half of the product shifts in through quo
  assign mul_sum = {1'b0, acc} + (quo[0] ? {1'b0, operand_b} : {(WIDTH+1){1'b0}});

  // One restoring step; the true difference is below the divisor so WIDTH bits suffice
  assign div_shift = {acc, quo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, operand_b});
  assign div_diff  = div_shift[WIDTH-1:0] - operand_b;

  assign prod_fix = cond_neg_wide({acc, quo}, neg_res);
  assign quo_fix  = cond_neg(quo, neg_res);
  assign rem_fix  = cond_neg(acc, neg_rem);

  assign busy   = (state != IDLE);
  assign out_64 = {hi, lo};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == LAST) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count        <= '0;
      acc          <= '0;
      quo          <= '0;
      operand_b    <= '0;
      dividend_raw <= '0;
      is_div       <= 1'b0;
      neg_res      <= 1'b0;
      neg_rem      <= 1'b0;
      div_zero     <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count        <= '0;
            acc          <= '0;
            quo          <= mag_a;
            operand_b    <= mag_b;
            dividend_raw <= in1;
            is_div       <= op[0];
            neg_res      <= a_neg ^ b_neg;
            neg_rem      <= a_neg;
            div_zero     <= (in2 == '0);
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        RUN: begin
          count <= count + CNT_W'(1);
          if (is_div) begin
            acc <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_sum[WIDTH:1];
            quo <= {mul_sum[0], quo[WIDTH-1:1]};
          end
        end
        FINISH: begin
          done <= 1'b1;
          if (is_div) begin
            // Divide by zero reports the raw dividend, bypassing sign fixup
            if (div_zero) begin
              hi <= dividend_raw;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
